// File: rtl/lms_weight_bank_if.sv
// Handshake and data bundle for the LMS tap-weight update engine.
// reff_i and weights_o pack tap i at bits [i*DW +: DW].
interface lms_weight_bank_if #(
    parameter int NTAPS = 16,
    parameter int DW    = 14
);
    logic                  start_i;
    logic                  clear_i;
    logic                  leak_en_i;
    logic [DW-1:0]         e_i;
    logic [NTAPS*DW-1:0]   reff_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  sat_flag_o;
    logic [NTAPS*DW-1:0]   weights_o;

    modport slave (
        input  start_i, clear_i, leak_en_i, e_i, reff_i,
        output busy_o, done_o, sat_flag_o, weights_o
    );

    modport master (
        output start_i, clear_i, leak_en_i, e_i, reff_i,
        input  busy_o, done_o, sat_flag_o, weights_o
    );
endinterface

// File: rtl/lms_weight_bank.sv
// Serial LMS weight update: w[i] <= sat(w[i] + ((e*reff[i]) >>> MU_SHIFT) - leak),
// one tap per cycle through a registered multiply and a saturating write-back stage.
module lms_weight_bank #(
    parameter int NTAPS      = 16,
    parameter int DW         = 14,
    parameter int MU_SHIFT   = 10,
    parameter int LEAK_SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    lms_weight_bank_if.slave   bus
);
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        pidx_q;
    logic                 pv_q;
    logic signed [DW-1:0] e_q;
    logic signed [DW-1:0] reff_q [NTAPS];
    logic                 leak_q;
    logic signed [PW-1:0] p_q;
    logic signed [DW-1:0] w_q [NTAPS];
    logic                 busy_q;
    logic                 done_q;
    logic                 sat_q;

    logic signed [PW-1:0] p_d;
    logic signed [DW-1:0] w_cur;
    logic signed [SW-1:0] wext, delta, lk, sum;
    logic signed [DW-1:0] wb_d;
    logic                 wb_sat_d;

    always_comb begin
        p_d      = PW'(e_q) * PW'(reff_q[idx_q]);
        w_cur    = w_q[pidx_q];
        wext     = $signed({{(SW-DW){w_cur[DW-1]}}, w_cur});
        delta    = $signed({{(SW-PW){p_q[PW-1]}}, p_q}) >>> MU_SHIFT;
        lk       = leak_q ? (wext >>> LEAK_SHIFT) : '0;
        sum      = wext + delta - lk;
        wb_d     = sum[DW-1:0];
        wb_sat_d = 1'b0;
        // In range only when every bit above the DW-bit sign position matches it.
        if (!((sum[SW-1:DW-1] == '0) || (sum[SW-1:DW-1] == '1))) begin
            wb_sat_d = 1'b1;
            wb_d     = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pidx_q  <= '0;
            pv_q    <= 1'b0;
            e_q     <= '0;
            leak_q  <= 1'b0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                reff_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else if (bus.clear_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            pv_q   <= 1'b0;
            if (pv_q) begin
                w_q[pidx_q] <= wb_d;
                if (wb_sat_d) begin
                    sat_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        e_q     <= $signed(bus.e_i);
                        leak_q  <= bus.leak_en_i;
                        for (int unsigned i = 0; i < NTAPS; i++) begin
                            reff_q[i] <= $signed(bus.reff_i[i*DW +: DW]);
                        end
                    end
                end
                RUN: begin
                    p_q    <= p_d;
                    pidx_q <= idx_q;
                    pv_q   <= 1'b1;
                    if (idx_q == IW'(NTAPS - 1)) begin
                        state_q <= FLUSH;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.weights_o = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            bus.weights_o[i*DW +: DW] = w_q[i];
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.sat_flag_o = sat_q;
endmodule

// File: tb/tb_lms_weight_bank.sv
// Scoreboard bench for lms_weight_bank: a behavioural weight model predicts each pass,
// expectations are queued at start and compared when done pulses.
module tb_lms_weight_bank;
    localparam int NTAPS = 16;
    localparam int DW    = 14;
    localparam int MU    = 4;
    localparam int LK    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lms_weight_bank_if #(.NTAPS(NTAPS), .DW(DW)) bus ();

    lms_weight_bank #(
        .NTAPS(NTAPS), .DW(DW), .MU_SHIFT(MU), .LEAK_SHIFT(LK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int w [NTAPS];
        bit sat;
    } exp_t;

    exp_t sb [$];
    int   mw [NTAPS];
    bit   msat;
    int   r  [NTAPS];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bc, dc;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wt(input int i);
        logic [DW-1:0] v;
        v = bus.weights_o[i*DW +: DW];
        return int'($signed(v));
    endfunction

    task automatic model_pass(input int e, input bit leak);
        longint p, d, lkv, s;
        for (int i = 0; i < NTAPS; i++) begin
            p   = longint'(e) * longint'(r[i]);
            d   = p >>> MU;
            lkv = leak ? longint'(mw[i] >>> LK) : 0;
            s   = longint'(mw[i]) + d - lkv;
            if (s > 8191) begin
                s = 8191; msat = 1'b1;
            end else if (s < -8192) begin
                s = -8192; msat = 1'b1;
            end
            mw[i] = int'(s);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NTAPS; i++) begin
            check($sformatf("%s_w%0d", tag, i), wt(i), mw[i]);
        end
        check({tag, "_sat"}, bus.sat_flag_o, msat);
    endtask

    task automatic drive_in(input int e, input bit leak);
        bus.e_i       = e[DW-1:0];
        bus.leak_en_i = leak;
        for (int i = 0; i < NTAPS; i++) begin
            bus.reff_i[i*DW +: DW] = r[i][DW-1:0];
        end
    endtask

    // One pass; optional start poke and clear at a given busy-cycle count.
    task automatic run_pass(input int e, input bit leak, input int poke_at, input int clear_at,
                            output int busy_cyc, output int done_cnt);
        exp_t x;
        int   guard;
        drive_in(e, leak);
        bus.start_i = 1'b1;
        if (clear_at == 0) begin
            model_pass(e, leak);
            x.w   = mw;
            x.sat = msat;
            sb.push_back(x);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.e_i     = '1;
        bus.reff_i  = '1;
        busy_cyc = 0;
        done_cnt = 0;
        guard    = 0;
        while (bus.busy_o && guard < 40) begin
            busy_cyc++;
            if (bus.done_o) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", done_cnt, 0);
                end else begin
                    x = sb.pop_front();
                    for (int i = 0; i < NTAPS; i++) begin
                        check($sformatf("pass_w%0d", i), wt(i), x.w[i]);
                    end
                    check("pass_sat", bus.sat_flag_o, x.sat);
                end
            end
            bus.start_i = (busy_cyc == poke_at);
            bus.clear_i = (busy_cyc == clear_at);
            guard++;
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        bus.clear_i = 1'b0;
        if (guard >= 40) check("busy_bound", guard, 39);
        check("done_after_pass", bus.done_o, 0);
        if (clear_at != 0) begin
            for (int i = 0; i < NTAPS; i++) mw[i] = 0;
            msat = 1'b0;
        end
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        for (int i = 0; i < NTAPS; i++) mw[i] = 0;
        msat = 1'b0;
        check_all("clear");
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0; bus.clear_i = 1'b0; bus.leak_en_i = 1'b0;
        bus.e_i = '0; bus.reff_i = '0;
        for (int i = 0; i < NTAPS; i++) begin mw[i] = 0; r[i] = 0; end
        msat = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check_all("rst");

        // T1: basic pass timing and values
        for (int i = 0; i < NTAPS; i++) r[i] = 10 * i;
        run_pass(100, 1'b0, 0, 0, bc, dc);
        check("t1_busy_cycles", bc, 18);
        check("t1_done_count", dc, 1);
        check("t1_w1", wt(1), 62);
        check("t1_w3", wt(3), 187);
        check("t1_w15", wt(15), 937);

        // T2: floor toward -inf
        do_clear();
        for (int i = 0; i < NTAPS; i++) r[i] = 1;
        run_pass(-1, 1'b0, 0, 0, bc, dc);
        check("t2_w7", wt(7), -1);
        check("t2_sat", bus.sat_flag_o, 0);

        // T3: positive then negative clamp
        do_clear();
        for (int i = 0; i < NTAPS; i++) r[i] = 0;
        r[0] = 8191;
        run_pass(8191, 1'b0, 0, 0, bc, dc);
        check("t3_w0_pos", wt(0), 8191);
        check("t3_sat", bus.sat_flag_o, 1);
        run_pass(-8192, 1'b0, 0, 0, bc, dc);
        run_pass(-8192, 1'b0, 0, 0, bc, dc);
        check("t3_w0_neg", wt(0), -8192);

        // T4: leakage
        do_clear();
        for (int i = 0; i < NTAPS; i++) r[i] = 0;
        r[0] = 16;
        run_pass(1024, 1'b0, 0, 0, bc, dc);
        check("t4_w0_init", wt(0), 1024);
        run_pass(0, 1'b1, 0, 0, bc, dc);
        check("t4_w0_leak", wt(0), 960);
        run_pass(0, 1'b0, 0, 0, bc, dc);
        check("t4_w0_noleak", wt(0), 960);

        // T5: start while busy ignored; clear aborts
        do_clear();
        for (int i = 0; i < NTAPS; i++) r[i] = 3 * i - 20;
        run_pass(500, 1'b0, 5, 0, bc, dc);
        check("t5_poke_busy", bc, 18);
        check("t5_poke_done", dc, 1);
        check("t5_idle_after_poke", bus.busy_o, 0);
        run_pass(300, 1'b0, 0, 8, bc, dc);
        check("t5_clear_busy", bc, 8);
        check("t5_clear_done", dc, 0);
        check_all("t5_clear");

        // clear and start together in IDLE: clear wins
        for (int i = 0; i < NTAPS; i++) r[i] = 5;
        drive_in(400, 1'b0);
        bus.start_i = 1'b1; bus.clear_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.clear_i = 1'b0;
        check("clr_start_busy", bus.busy_o, 0);
        @(negedge clk);
        check("clr_start_busy2", bus.busy_o, 0);
        check_all("clr_start");

        // T6: asynchronous reset mid-pass
        for (int i = 0; i < NTAPS; i++) r[i] = 7 * i + 1;
        run_pass(2000, 1'b0, 0, 0, bc, dc);
        drive_in(-250, 1'b1);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NTAPS; i++) mw[i] = 0;
        msat = 1'b0;
        sb.delete();
        check("t6_busy", bus.busy_o, 0);
        check("t6_done", bus.done_o, 0);
        check_all("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_pass(-250, 1'b1, 0, 0, bc, dc);
        check("t6_busy_cycles", bc, 18);
        check("t6_done_count", dc, 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
